mac_result_capture: RTL and testbench

//  Receive-side monitor for the configurable approximate MAC. Aligns the operands presented
//  to the MAC with the MAC result d, which appears MAC_LATENCY cycles later. Buffers each
//  {a,b,d} triple in a first-word-fall-through FIFO and drains it over a valid/ready port.

---
 rtl/mac_result_capture.sv | 225 ++++++++++++++++++++++
 tb/tb_mac_result_capture.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mac_result_capture.sv
// Captures {a, b, d} triples from an approximate MAC, aligned by MAC_LATENCY, into a FWFT FIFO.
// Optional reference-accumulator checking is built when CAPTURE_CHECK_EN is defined.
module mac_result_capture #(
  parameter int OP_BITWIDTH        = 32,
  parameter int DATA_PATH_BITWIDTH = 32,
  parameter int MAC_LATENCY        = 1,
  parameter int DEPTH              = 16,
  parameter int CNT_W              = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [OP_BITWIDTH-1:0]        a,
  input  logic [OP_BITWIDTH-1:0]        b,
  input  logic                          acc_clr,
  input  logic [DATA_PATH_BITWIDTH-1:0] d,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OP_BITWIDTH-1:0]        out_a,
  output logic [OP_BITWIDTH-1:0]        out_b,
  output logic [DATA_PATH_BITWIDTH-1:0] out_d,
  output logic                          overflow,
  output logic [CNT_W-1:0]              sample_cnt,
  output logic [CNT_W-1:0]              drop_cnt,
  output logic [CNT_W-1:0]              err_cnt
);

  localparam int AW      = $clog2(DEPTH);
  localparam int PW      = AW + 1;
  localparam int ENTRY_W = 2 * OP_BITWIDTH + DATA_PATH_BITWIDTH;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  // ---------------------------------------------------------------------------
  // Operand alignment pipeline
  // ---------------------------------------------------------------------------
  logic [MAC_LATENCY-1:0] v_pipe_q;
  logic [MAC_LATENCY-1:0] clr_pipe_q;
  logic [OP_BITWIDTH-1:0] a_pipe_q [MAC_LATENCY];
  logic [OP_BITWIDTH-1:0] b_pipe_q [MAC_LATENCY];

  logic                   av;
  logic                   aclr;
  logic [OP_BITWIDTH-1:0] aa;
  logic [OP_BITWIDTH-1:0] ab;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_pipe_q   <= '0;
      clr_pipe_q <= '0;
    end else if (flush) begin
      v_pipe_q   <= '0;
      clr_pipe_q <= '0;
    end else begin
      v_pipe_q[0]   <= in_valid;
      clr_pipe_q[0] <= acc_clr;
      for (int i = 1; i < MAC_LATENCY; i++) begin
        v_pipe_q[i]   <= v_pipe_q[i-1];
        clr_pipe_q[i] <= clr_pipe_q[i-1];
      end
    end
  end

  // Operand data is qualified by v_pipe_q, so it needs no reset.
  always_ff @(posedge clk) begin
    a_pipe_q[0] <= a;
    b_pipe_q[0] <= b;
    for (int i = 1; i < MAC_LATENCY; i++) begin
      a_pipe_q[i] <= a_pipe_q[i-1];
      b_pipe_q[i] <= b_pipe_q[i-1];
    end
  end

  assign av   = v_pipe_q[MAC_LATENCY-1];
  assign aclr = clr_pipe_q[MAC_LATENCY-1];
  assign aa   = a_pipe_q[MAC_LATENCY-1];
  assign ab   = b_pipe_q[MAC_LATENCY-1];

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push_ok;
  logic          drop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop     = out_valid && out_ready && !flush;
  assign push_ok = av && (!full || pop) && !flush;
  assign drop    = av && full && !pop && !flush;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage and head read-out
  // ---------------------------------------------------------------------------
  logic [ENTRY_W-1:0]            mem_q [DEPTH];
  logic [OP_BITWIDTH-1:0]        head_a;
  logic [OP_BITWIDTH-1:0]        head_b;
  logic [DATA_PATH_BITWIDTH-1:0] head_d;

  // NOTE: the RAM is deliberately not reset; pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= {aa, ab, d};
  end

  assign {head_a, head_b, head_d} = mem_q[rd_ptr_q[AW-1:0]];

  // Gating the head keeps outputs at zero while empty, including straight out of reset.
  assign out_valid = !empty;
  assign out_a     = out_valid ? head_a : '0;
  assign out_b     = out_valid ? head_b : '0;
  assign out_d     = out_valid ? head_d : '0;

  // ---------------------------------------------------------------------------
  // Status counters
  // ---------------------------------------------------------------------------
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    overflow_d   = overflow_q | drop;
    sample_cnt_d = sat_inc(sample_cnt_q, push_ok);
    drop_cnt_d   = sat_inc(drop_cnt_q, drop);
    if (flush) begin
      overflow_d   = 1'b0;
      sample_cnt_d = '0;
      drop_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q   <= 1'b0;
      sample_cnt_q <= '0;
      drop_cnt_q   <= '0;
    end else begin
      overflow_q   <= overflow_d;
      sample_cnt_q <= sample_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign overflow   = overflow_q;
  assign sample_cnt = sample_cnt_q;
  assign drop_cnt   = drop_cnt_q;

  // ---------------------------------------------------------------------------
  // Reference checking
  // ---------------------------------------------------------------------------
`ifdef CAPTURE_CHECK_EN
  logic signed [2*OP_BITWIDTH-1:0] prod;
  logic [DATA_PATH_BITWIDTH-1:0]   prod_trunc;
  logic [DATA_PATH_BITWIDTH-1:0]   ref_sum;
  logic [DATA_PATH_BITWIDTH-1:0]   ref_acc_q, ref_acc_d;
  logic [CNT_W-1:0]                err_cnt_q, err_cnt_d;

  assign prod       = $signed(aa) * $signed(ab);
  assign prod_trunc = DATA_PATH_BITWIDTH'(prod);
  // A clear arriving with an operand applies to that operand, matching the MAC's own clear.
  assign ref_sum    = (aclr ? '0 : ref_acc_q) + prod_trunc;

  always_comb begin
    ref_acc_d = ref_acc_q;
    err_cnt_d = err_cnt_q;
    if (flush) begin
      ref_acc_d = '0;
      err_cnt_d = '0;
    end else if (av) begin
      ref_acc_d = ref_sum;
      err_cnt_d = sat_inc(err_cnt_q, d != ref_sum);
    end else if (aclr) begin
      ref_acc_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_acc_q <= '0;
      err_cnt_q <= '0;
    end else begin
      ref_acc_q <= ref_acc_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_aclr;

  assign unused_aclr = aclr;
  assign err_cnt     = '0;
`endif

endmodule

// File: tb/tb_mac_result_capture.sv
// Directed bench for mac_result_capture: reset, alignment, overflow, full+pop+push, flush, check.
module tb_mac_result_capture;

  localparam int OPW = 32;
  localparam int DPW = 32;
  localparam int CW  = 16;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic [OPW-1:0] a;
  logic [OPW-1:0] b;
  logic           acc_clr;
  logic [DPW-1:0] d;
  logic           flush;
  logic           out_valid;
  logic           out_ready;
  logic [OPW-1:0] out_a;
  logic [OPW-1:0] out_b;
  logic [DPW-1:0] out_d;
  logic           overflow;
  logic [CW-1:0]  sample_cnt;
  logic [CW-1:0]  drop_cnt;
  logic [CW-1:0]  err_cnt;

  logic [DPW-1:0] pend_d;
  int             checks;
  int             errors;
  logic [CW-1:0]  exp_err;

  mac_result_capture #(
    .OP_BITWIDTH       (OPW),
    .DATA_PATH_BITWIDTH(DPW),
    .MAC_LATENCY       (1),
    .DEPTH             (16),
    .CNT_W             (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .acc_clr   (acc_clr),
    .d         (d),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_d     (out_d),
    .overflow  (overflow),
    .sample_cnt(sample_cnt),
    .drop_cnt  (drop_cnt),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one operand cycle; d carries the MAC result for the previous cycle's operands.
  task automatic cycle(input logic v, input logic [OPW-1:0] aa, input logic [OPW-1:0] bb,
                       input logic clr, input logic [DPW-1:0] dres);
    d        = pend_d;
    in_valid = v;
    a        = aa;
    b        = bb;
    acc_clr  = clr;
    pend_d   = dres;
    tick();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    acc_clr   = 1'b0;
    d         = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    pend_d    = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset / idle
    check("rst_valid", out_valid, 0);
    check("rst_ovf", overflow, 0);
    check("rst_sample", sample_cnt, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_err", err_cnt, 0);
    check("rst_out_a", out_a, 0);

    // Alignment: operands at t, d at t+1, head at t+2
    out_ready = 1'b1;
    cycle(1'b1, 3, 5, 1'b0, 15);
    check("align_early", out_valid, 0);
    cycle(1'b0, 0, 0, 1'b0, 0);
    check("align_valid", out_valid, 1);
    check("align_a", out_a, 3);
    check("align_b", out_b, 5);
    check("align_d", out_d, 15);
    check("align_sample", sample_cnt, 1);
    tick();
    check("align_popped", out_valid, 0);

    // Overflow: 20 samples into a 16-deep FIFO with no consumer
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) cycle(1'b1, i, i + 100, 1'b0, i * 3);
    cycle(1'b0, 0, 0, 1'b0, 0);
    check("ovf_sample", sample_cnt, 17);
    check("ovf_drop", drop_cnt, 4);
    check("ovf_flag", overflow, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("ovf_drain_a", out_a, i);
      check("ovf_drain_b", out_b, i + 100);
      tick();
    end
    check("ovf_empty", out_valid, 0);
    out_ready = 1'b0;

    // Flush of an idle design clears sticky state
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush0_ovf", overflow, 0);
    check("flush0_drop", drop_cnt, 0);
    check("flush0_sample", sample_cnt, 0);

    // Full + pop + push keeps occupancy at 16 with no drop
    for (int i = 0; i < 16; i++) cycle(1'b1, 200 + i, 1, 1'b0, 0);
    cycle(1'b0, 0, 0, 1'b0, 0);
    check("fpp_fill_sample", sample_cnt, 16);
    check("fpp_fill_head", out_a, 200);
    cycle(1'b1, 300, 1, 1'b0, 0);
    out_ready = 1'b1;
    cycle(1'b0, 0, 0, 1'b0, 0);
    out_ready = 1'b0;
    check("fpp_drop", drop_cnt, 0);
    check("fpp_sample", sample_cnt, 17);
    check("fpp_ovf", overflow, 0);
    check("fpp_head", out_a, 201);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("fpp_drain", out_a, (i < 15) ? 201 + i : 300);
      tick();
    end
    check("fpp_empty", out_valid, 0);
    out_ready = 1'b0;

    // Flush mid-stream with 5 queued entries and a sample in flight
    for (int i = 0; i < 5; i++) cycle(1'b1, 400 + i, 1, 1'b0, 0);
    cycle(1'b1, 500, 1, 1'b0, 0);
    check("fl_pre_sample", sample_cnt, 22);
    check("fl_pre_valid", out_valid, 1);
    flush = 1'b1;
    cycle(1'b1, 600, 1, 1'b0, 0);
    flush = 1'b0;
    check("fl_valid", out_valid, 0);
    check("fl_sample", sample_cnt, 0);
    check("fl_drop", drop_cnt, 0);
    check("fl_ovf", overflow, 0);
    check("fl_err", err_cnt, 0);
    cycle(1'b0, 0, 0, 1'b0, 0);
    check("fl_post_valid", out_valid, 0);
    check("fl_post_sample", sample_cnt, 0);
    tick();
    check("fl_post2_valid", out_valid, 0);

    // Reference check: matching accumulation, then a clear with a wrong d
    out_ready = 1'b1;
    cycle(1'b1, 2, 3, 1'b0, 6);
    cycle(1'b1, 4, -1, 1'b0, 2);
    cycle(1'b1, -7, 7, 1'b0, -47);
    cycle(1'b0, 0, 0, 1'b0, 0);
    check("chk_err_match", err_cnt, 0);
    check("chk_sample", sample_cnt, 3);
    cycle(1'b1, 1, 1, 1'b1, 2);
    cycle(1'b0, 0, 0, 1'b0, 0);
`ifdef CAPTURE_CHECK_EN
    exp_err = 1;
`else
    exp_err = 0;
`endif
    check("chk_err_clr", err_cnt, exp_err);
    tick();
    out_ready = 1'b0;

    // Reset mid-transfer discards queued entries
    cycle(1'b1, 7, 7, 1'b0, 0);
    cycle(1'b1, 8, 8, 1'b0, 0);
    cycle(1'b0, 0, 0, 1'b0, 0);
    check("mrst_pre_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("mrst_valid", out_valid, 0);
    check("mrst_sample", sample_cnt, 0);
    tick();
    rst = 1'b0;
    tick();
    check("mrst_post_valid", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
